// File: rtl/nxn_single_crossbar_ctrl_if.sv
// rtl/nxn_single_crossbar_ctrl_if.sv - handshake bundle between port buffers, crossbar and controller
// master: buffer/crossbar side; slave: the arbiter/sequencer.
interface nxn_single_crossbar_ctrl_if #(
   parameter int PORT_N = 5,
   parameter int SEL_W  = $clog2(PORT_N)
);
   logic [PORT_N-1:0]       req_i;
   logic [PORT_N*SEL_W-1:0] dst_i;
   logic [PORT_N-1:0]       last_i;
   logic [PORT_N-1:0]       out_rdy_i;
   logic [PORT_N-1:0]       ack_o;
   logic [SEL_W-1:0]        in_sel_o;
   logic [SEL_W-1:0]        out_sel_o;
   logic                    xfer_vld_o;
   logic [PORT_N-1:0]       out_vld_o;
   logic                    busy_o;
   logic                    timeout_o;

   modport master (
      output req_i, dst_i, last_i, out_rdy_i,
      input  ack_o, in_sel_o, out_sel_o, xfer_vld_o, out_vld_o, busy_o, timeout_o
   );

   modport slave (
      input  req_i, dst_i, last_i, out_rdy_i,
      output ack_o, in_sel_o, out_sel_o, xfer_vld_o, out_vld_o, busy_o, timeout_o
   );
endinterface

// File: rtl/nxn_single_crossbar_ctrl.sv
// rtl/nxn_single_crossbar_ctrl.sv - round-robin packet arbiter/sequencer for a single-path NxN crossbar
// Optional stall watchdog with forced release: define XBAR_CTRL_TIMEOUT_EN.
module nxn_single_crossbar_ctrl #(
   parameter int PORT_N      = 5,
   parameter int SEL_W       = $clog2(PORT_N),
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   nxn_single_crossbar_ctrl_if.slave bus
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t            state;
   logic [SEL_W-1:0]  rr_ptr;
   logic [SEL_W-1:0]  in_sel;
   logic [SEL_W-1:0]  out_sel;

   logic [PORT_N-1:0] elig;
   logic              found;
   logic [SEL_W-1:0]  win;
   logic [SEL_W-1:0]  win_dst;
   logic [SEL_W-1:0]  next_ptr;
   logic              xfer;
   logic [PORT_N-1:0] ack;
   logic [PORT_N-1:0] out_vld;
   int                idx;

`ifdef XBAR_CTRL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]  stall_cnt;
   logic              timeout_q;
`endif

   // A request whose destination is out of range is invisible to arbitration.
   always_comb begin
      elig = '0;
      for (int k = 0; k < PORT_N; k++) begin
         elig[k] = bus.req_i[k] && (int'(bus.dst_i[SEL_W*k +: SEL_W]) < PORT_N);
      end
   end

   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int i = 0; i < PORT_N; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= PORT_N) idx = idx - PORT_N;
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = SEL_W'(idx);
         end
      end
   end

   assign win_dst  = bus.dst_i[SEL_W*int'(win) +: SEL_W];
   assign next_ptr = (int'(in_sel) == PORT_N - 1) ? '0 : in_sel + SEL_W'(1);
   assign xfer     = (state == LOCKED) && bus.req_i[in_sel] && bus.out_rdy_i[out_sel];

   always_comb begin
      ack     = '0;
      out_vld = '0;
      if (xfer) begin
         ack[in_sel]     = 1'b1;
         out_vld[out_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         in_sel  <= '0;
         out_sel <= '0;
`ifdef XBAR_CTRL_TIMEOUT_EN
         stall_cnt <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
`ifdef XBAR_CTRL_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (found) begin
                  in_sel  <= win;
                  out_sel <= win_dst;
                  state   <= LOCKED;
`ifdef XBAR_CTRL_TIMEOUT_EN
                  stall_cnt <= '0;
`endif
               end
            end
            LOCKED: begin
               if (xfer) begin
`ifdef XBAR_CTRL_TIMEOUT_EN
                  stall_cnt <= '0;
`endif
                  if (bus.last_i[in_sel]) begin
                     state  <= IDLE;
                     rr_ptr <= next_ptr;
                  end
               end
`ifdef XBAR_CTRL_TIMEOUT_EN
               // Watchdog release: the stalled packet is dropped without an ack.
               else if (stall_cnt == CNT_W'(TIMEOUT_CYC)) begin
                  state     <= IDLE;
                  rr_ptr    <= next_ptr;
                  stall_cnt <= '0;
                  timeout_q <= 1'b1;
               end else begin
                  stall_cnt <= stall_cnt + CNT_W'(1);
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ack_o      = ack;
   assign bus.out_vld_o  = out_vld;
   assign bus.xfer_vld_o = xfer;
   assign bus.in_sel_o   = in_sel;
   assign bus.out_sel_o  = out_sel;
   assign bus.busy_o     = (state == LOCKED);

`ifdef XBAR_CTRL_TIMEOUT_EN
   assign bus.timeout_o = timeout_q;
`else
   // Always 0: the watchdog is absent, TIMEOUT_CYC only appears to keep it referenced.
   assign bus.timeout_o = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_nxn_single_crossbar_ctrl.sv
// tb/tb_nxn_single_crossbar_ctrl.sv - directed and randomized self-check of nxn_single_crossbar_ctrl
// Reference model tracks lock/owner/pointer as plain integers and predicts every output each cycle.
module tb_nxn_single_crossbar_ctrl;

   localparam int N  = 5;
   localparam int SW = 3;
   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   nxn_single_crossbar_ctrl_if #(.PORT_N(N)) bus ();

   nxn_single_crossbar_ctrl #(.PORT_N(N), .TIMEOUT_CYC(TO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   logic [N-1:0] req;
   logic [N-1:0] last;
   logic [N-1:0] rdy;
   int           dst [N];

   bit m_lock;
   int m_in, m_out, m_ptr, m_cnt;
   bit m_to;

   logic [N-1:0] s_ack;
   logic         s_xfer, s_busy, s_to;
   int           s_in, s_out;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.req_i     = req;
      bus.last_i    = last;
      bus.out_rdy_i = rdy;
      for (int k = 0; k < N; k++) bus.dst_i[SW*k +: SW] = SW'(dst[k]);
   endtask

   task automatic tick();
      logic         t;
      logic [N-1:0] e_ack, e_ov;
      drive();
      @(negedge clk);
      t     = m_lock && req[m_in] && rdy[m_out];
      e_ack = t ? (N'(1) << m_in) : '0;
      e_ov  = t ? (N'(1) << m_out) : '0;
      chk("busy", bus.busy_o, m_lock);
      chk("in_sel", bus.in_sel_o, m_in);
      chk("out_sel", bus.out_sel_o, m_out);
      chk("ack", bus.ack_o, e_ack);
      chk("xfer_vld", bus.xfer_vld_o, t);
      chk("out_vld", bus.out_vld_o, e_ov);
      chk("timeout", bus.timeout_o, m_to);
      s_ack  = bus.ack_o;
      s_xfer = bus.xfer_vld_o;
      s_busy = bus.busy_o;
      s_to   = bus.timeout_o;
      s_in   = int'(bus.in_sel_o);
      s_out  = int'(bus.out_sel_o);
      @(posedge clk);
      m_to = 1'b0;
      if (rst) begin
         m_lock = 1'b0; m_ptr = 0; m_in = 0; m_out = 0; m_cnt = 0;
      end else if (!m_lock) begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (req[k] && dst[k] < N) begin
               m_lock = 1'b1; m_in = k; m_out = dst[k]; m_cnt = 0;
               break;
            end
         end
      end else if (t) begin
         m_cnt = 0;
         if (last[m_in]) begin
            m_lock = 1'b0;
            m_ptr  = (m_in + 1) % N;
         end
      end
`ifdef XBAR_CTRL_TIMEOUT_EN
      else if (m_cnt == TO) begin
         m_lock = 1'b0; m_ptr = (m_in + 1) % N; m_cnt = 0; m_to = 1'b1;
      end else begin
         m_cnt++;
      end
`endif
      #1;
   endtask

   initial begin
      int got [$];
      int exp_ord [6];
      int to_pulses;
      bit ack3_seen;

      exp_ord = '{0, 1, 2, 3, 4, 0};
      req = '0; last = '0; rdy = '0;
      for (int k = 0; k < N; k++) dst[k] = 0;
      m_lock = 0; m_in = 0; m_out = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
      rst = 1'b1;
      drive();
      @(posedge clk);
      #1;
      tick();

      // Reset mid-packet
      rst = 1'b0; req = 5'b00100; dst[2] = 4; last = '0; rdy = '1;
      tick();
      tick();
      chk("t1_locked_ack", s_ack, 5'b00100);
      rst = 1'b1;
      tick();
      rst = 1'b0; req = '0;
      tick();
      chk("t1_busy_after_rst", s_busy, 0);
      chk("t1_in_sel_after_rst", s_in, 0);
      chk("t1_out_sel_after_rst", s_out, 0);
      chk("t1_ack_after_rst", s_ack, 0);

      // Round-robin fairness with single-flit packets
      req = '1; last = '1; rdy = '1;
      for (int k = 0; k < N; k++) dst[k] = (k + 1) % N;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (s_xfer) got.push_back(s_in);
      end
      chk("t2_grant_count", got.size(), 6);
      for (int i = 0; i < 6 && i < got.size(); i++) chk("t2_grant_order", got[i], exp_ord[i]);

      // Multi-flit lock holds out a competing requester
      req = 5'b00011; last = '0; dst[1] = 3; dst[0] = 2;
      tick();
      for (int f = 0; f < 3; f++) begin
         if (f == 2) last = 5'b00011;
         tick();
         chk("t3_ack", s_ack, 5'b00010);
         chk("t3_in_sel", s_in, 1);
      end
      req = 5'b00001;
      tick();
      tick();
      chk("t3_next_grant", s_in, 0);
      chk("t3_next_xfer", s_xfer, 1);
      req = '0;
      tick();

      // Backpressure on output 2
      req = 5'b00001; dst[0] = 2; last = '0; rdy = '1;
      tick();
      rdy = 5'b11011;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("t4_stall_xfer", s_xfer, 0);
         chk("t4_stall_ack", s_ack, 0);
      end
      rdy = '1; last = '1;
      tick();
      chk("t4_resume_xfer", s_xfer, 1);
      chk("t4_resume_sel", {s_in[15:0], s_out[15:0]}, {16'd0, 16'd2});
      req = '0;
      tick();

      // Out-of-range destination is never granted
      req = 5'b11000; dst[3] = 6; dst[4] = 1; last = '1;
      ack3_seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (s_ack[3]) ack3_seen = 1'b1;
         if (s_xfer) chk("t5_winner", s_in, 4);
      end
      chk("t5_no_ack3", ack3_seen, 0);
      req = '0;
      tick();

`ifdef XBAR_CTRL_TIMEOUT_EN
      // Watchdog release after the owner drops its request
      rst = 1'b1; tick(); rst = 1'b0;
      req = 5'b00100; dst[2] = 0; last = '0;
      tick();
      req = '0;
      to_pulses = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (s_to) to_pulses++;
      end
      chk("t6_timeout_pulses", to_pulses, 1);
      req = '1; last = '1;
      for (int k = 0; k < N; k++) dst[k] = (k + 1) % N;
      tick();
      tick();
      chk("t6_winner_after_timeout", s_in, 3);
      req = '0;
      tick();
`else
      to_pulses = 0;
`endif

      // Randomized traffic against the reference model
      for (int c = 0; c < 600; c++) begin
         rst  = ($urandom_range(0, 63) == 0);
         req  = N'($urandom);
         last = N'($urandom & $urandom);
         rdy  = N'($urandom | $urandom);
         for (int k = 0; k < N; k++) dst[k] = $urandom_range(0, 6);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
